test_status_monitor: RTL

- Synthesisable, non-intrusive observer placed directly downstream of the CPU register-file writeback port in RISCV_SOC.
- Consumes the same writeback stream the register file consumes; never drives the CPU.
- Implements the riscv-tests completion convention: x26 written with 1 means the test has finished; x27 == 1 at that point means pass; x3 holds the failing test number.
- Gives benches and FPGA builds sticky done/pass/timeout flags plus frozen cycle and retire counts, without hierarchical peeking into the register file.

---
 rtl/test_status_monitor_if.sv | 24 ++
 rtl/test_status_monitor.sv | 124 ++++++++++++
 2 files changed

// File: rtl/test_status_monitor_if.sv
// Register-file writeback stream as seen by the test status monitor.
// The CPU side drives it; the monitor only listens.
interface test_status_monitor_if #(
   parameter int XLEN = 64
);
   logic            wb_en;
   logic [4:0]      wb_addr;
   logic [XLEN-1:0] wb_data;
   logic            inst_retire;

   modport master (
      output wb_en,
      output wb_addr,
      output wb_data,
      output inst_retire
   );

   modport slave (
      input wb_en,
      input wb_addr,
      input wb_data,
      input inst_retire
   );
endinterface

// File: rtl/test_status_monitor.sv
// Passive riscv-tests completion observer on the writeback port:
// sticky done/pass/timeout plus frozen cycle and retire counts.
module test_status_monitor #(
   parameter int XLEN           = 64,
   parameter int DRAIN_CYCLES   = 100,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int CNT_W          = 32
) (
   input  logic             clk,
   input  logic             rst,
   test_status_monitor_if.slave wb,
   output logic             done,
   output logic             pass,
   output logic             timeout,
   output logic [31:0]      fail_testnum,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] retire_count,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2,
      TOUT  = 2'd3
   } st_t;

   st_t             st_q, st_d;
   logic [CNT_W-1:0] drain_q, drain_d;
   logic [31:0]     sh3_q, sh3_d;
   logic [XLEN-1:0] sh27_q, sh27_d;
   logic [CNT_W-1:0] cyc_d, ret_d;
   logic            done_d, pass_d, tout_d;
   logic [31:0]     fail_d;
   logic            live, trig, expire;

   assign state = st_q;
   assign live  = (st_q == RUN) || (st_q == DRAIN);
   assign trig  = wb.wb_en && (wb.wb_addr == 5'd26)
               && (wb.wb_data == XLEN'(1));
   assign expire = (TIMEOUT_CYCLES != 0)
                && (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      st_d    = st_q;
      drain_d = drain_q;
      sh3_d   = sh3_q;
      sh27_d  = sh27_q;
      cyc_d   = cycle_count;
      ret_d   = retire_count;
      done_d  = done;
      pass_d  = pass;
      tout_d  = timeout;
      fail_d  = fail_testnum;

      // x26 is never stored: only its trigger value matters
      if (live && wb.wb_en) begin
         if (wb.wb_addr == 5'd3)  sh3_d  = wb.wb_data[31:0];
         if (wb.wb_addr == 5'd27) sh27_d = wb.wb_data;
      end

      if (live) begin
         if (!(&cycle_count)) cyc_d = cycle_count + CNT_W'(1);
         if (wb.inst_retire && !(&retire_count))
            ret_d = retire_count + CNT_W'(1);
      end

      unique case (st_q)
         RUN: begin
            if (trig) begin
               st_d    = DRAIN;
               drain_d = CNT_W'(DRAIN_CYCLES);
            end else if (expire) begin
               st_d   = TOUT;
               done_d = 1'b1;
               pass_d = 1'b0;
               tout_d = 1'b1;
               fail_d = sh3_d;
            end
         end
         DRAIN: begin
            if (drain_q == '0) begin
               // sample includes a write landing on this last cycle
               st_d   = DONE;
               done_d = 1'b1;
               pass_d = (sh27_d == XLEN'(1));
               tout_d = 1'b0;
               fail_d = pass_d ? 32'd0 : sh3_d;
            end else begin
               drain_d = drain_q - CNT_W'(1);
            end
         end
         DONE: ;
         TOUT: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         st_q         <= RUN;
         drain_q      <= '0;
         sh3_q        <= '0;
         sh27_q       <= '0;
         cycle_count  <= '0;
         retire_count <= '0;
         done         <= 1'b0;
         pass         <= 1'b0;
         timeout      <= 1'b0;
         fail_testnum <= '0;
      end else begin
         st_q         <= st_d;
         drain_q      <= drain_d;
         sh3_q        <= sh3_d;
         sh27_q       <= sh27_d;
         cycle_count  <= cyc_d;
         retire_count <= ret_d;
         done         <= done_d;
         pass         <= pass_d;
         timeout      <= tout_d;
         fail_testnum <= fail_d;
      end
   end

endmodule
